// File: rtl/async_fifo_flags.sv
// async_fifo_flags: dual-clock FIFO with gray-code pointer crossing, per-domain counts,
// programmable almost flags and sticky overflow/underflow.
module async_fifo_flags #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 6,
  parameter int AE_LEVEL    = 2
) (
  input  logic              wr_clk,
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              wr_overflow,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              rd_underflow
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t AF = ptr_t'(AF_LEVEL);
  localparam ptr_t AE = ptr_t'(AE_LEVEL);

  function automatic ptr_t g2b(input ptr_t g);
    ptr_t b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wbin_q, wgray_q, wbin_d, wgray_d, wcount_q, wcount_d, rs, rs_bin;
  ptr_t rbin_q, rgray_q, rbin_d, rgray_d, rcount_q, rcount_d, ws, ws_bin;
  logic [SYNC_STAGES-1:0][ADDR_W:0] rsync_q, wsync_q;
  logic full_q, full_d, af_q, ovf_q, wr_push;
  logic empty_q, empty_d, ae_q, udf_q, rv_q, rd_pop;
  logic [WIDTH-1:0] rdata_q;

  assign rs       = rsync_q[SYNC_STAGES-1];
  assign rs_bin   = g2b(rs);
  assign wr_push  = wr_en && !full_q;
  assign wbin_d   = wbin_q + ptr_t'(wr_push);
  assign wgray_d  = wbin_d ^ (wbin_d >> 1);
  // full when the next write pointer laps the synced read pointer by exactly DEPTH
  assign full_d   = wgray_d == {~rs[ADDR_W:ADDR_W-1], rs[ADDR_W-2:0]};
  assign wcount_d = wbin_d - rs_bin;

  always_ff @(posedge wr_clk)
    if (wr_push) mem[wbin_q[ADDR_W-1:0]] <= wr_data;

  always_ff @(posedge wr_clk or posedge rst)
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync_q  <= {rsync_q[SYNC_STAGES-2:0], rgray_q};
      full_q   <= full_d;
      af_q     <= wcount_d >= AF;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_q | (wr_en && full_q);
    end

  assign ws       = wsync_q[SYNC_STAGES-1];
  assign ws_bin   = g2b(ws);
  assign rd_pop   = rd_en && !empty_q;
  assign rbin_d   = rbin_q + ptr_t'(rd_pop);
  assign rgray_d  = rbin_d ^ (rbin_d >> 1);
  assign empty_d  = rgray_d == ws;
  assign rcount_d = ws_bin - rbin_d;

  always_ff @(posedge rd_clk or posedge rst)
    if (rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      wsync_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      rcount_q <= '0;
      udf_q    <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wsync_q  <= {wsync_q[SYNC_STAGES-2:0], wgray_q};
      empty_q  <= empty_d;
      ae_q     <= rcount_d <= AE;
      rcount_q <= rcount_d;
      udf_q    <= udf_q | (rd_en && empty_q);
      rv_q     <= rd_pop;
      rdata_q  <= rd_pop ? mem[rbin_q[ADDR_W-1:0]] : rdata_q;
    end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign wr_count     = wcount_q;
  assign wr_overflow  = ovf_q;
  assign rd_data      = rdata_q;
  assign rd_valid     = rv_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_count     = rcount_q;
  assign rd_underflow = udf_q;
endmodule
